lab_probe_trace: RTL and testbench

Parametrised debug-trace capture unit for the lab top, the successor to wiring CPU debug signals directly to the 16-bit output registers. It samples NCH probe channels of W bits on every single-step pulse and stores them in a DEPTH-entry ring history. Free-run and triggered capture are supported. Any history entry can be read back onto the platform output registers while the CPU is stepped.

---
 rtl/lab_probe_trace.sv | 246 ++++++++++++++++++++++++
 tb/tb_lab_probe_trace.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab_probe_trace.sv
// ---------------------------------------------------------------------------
// lab_probe_trace
//
// Debug-trace capture unit. NCH probe channels of W bits are sampled on every
// rising edge of the asynchronous single-step signal and written into a
// DEPTH-entry ring history. A session is started by a rising edge of arm and
// ends on stop, or, in triggered mode, post_len captures after the trigger
// sample. Any history entry can be read back at any time, newest first.
//
// Optional feature macro: LAB_PROBE_TRIG_EN
//   defined     -> trigger comparator, post counter and POST state built in
//   not defined -> trigger inputs ignored, o_triggered tied low, RUN ends
//                  only on stop
//
// Ports:
//   i_lab_clk      platform clock, the only clock
//   i_lab_reset    asynchronous active-low reset
//   i_step_clk     step signal (async); its rising edge is the capture event
//   i_probe_in     flattened channels, channel k at [k*W +: W]
//   i_arm          rising edge starts a capture session
//   i_stop         high level ends a running session
//   i_trig_en      triggered mode for the next session
//   i_trig_ch      trigger channel (modulo NCH)
//   i_trig_val     trigger match value
//   i_post_len     captures after the trigger sample
//   i_rd_idx       history index, 0 = newest
//   o_rd_data      registered history entry at i_rd_idx (zero if invalid)
//   o_count        valid entries, saturates at DEPTH
//   o_state        0 IDLE, 1 RUN, 2 POST, 3 DONE
//   o_triggered    trigger seen in the current session
//   o_step_cnt     step edges since reset, wraps
// ---------------------------------------------------------------------------
module lab_probe_trace #(
    parameter int NCH   = 8,
    parameter int W     = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               i_lab_clk,
    input  logic               i_lab_reset,
    input  logic               i_step_clk,
    input  logic [NCH*W-1:0]   i_probe_in,
    input  logic               i_arm,
    input  logic               i_stop,
    input  logic               i_trig_en,
    input  logic [2:0]         i_trig_ch,
    input  logic [W-1:0]       i_trig_val,
    input  logic [AW-1:0]      i_post_len,
    input  logic [AW-1:0]      i_rd_idx,
    output logic [NCH*W-1:0]   o_rd_data,
    output logic [AW:0]        o_count,
    output logic [1:0]         o_state,
    output logic               o_triggered,
    output logic [31:0]        o_step_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic               r_stepS1;
    logic               r_stepS2;
    logic               r_stepD;
    logic               r_armD;
    logic               w_stepStrobe;
    logic               w_armRise;
    logic               w_capture;
    logic               w_startSession;
    logic               w_trigHit;

    logic [AW-1:0]      r_wptr;
    logic [AW:0]        r_count;
    logic               r_triggered;
    logic [31:0]        r_stepCnt;
    logic [NCH*W-1:0]   r_rdData;
    logic [AW-1:0]      w_rdAddr;

    logic [NCH*W-1:0]   r_mem [DEPTH];

`ifdef LAB_PROBE_TRIG_EN
    logic               r_trigEn;
    logic [2:0]         r_trigCh;
    logic [W-1:0]       r_trigVal;
    logic [AW-1:0]      r_postLen;
    logic [AW-1:0]      r_postCnt;
    logic [W-1:0]       w_trigSample;

    // Trigger channel mux; every 3-bit select value maps to channel (sel mod NCH)
    always_comb begin
        w_trigSample = '0;
        for (int k = 0; k < 8; k++) begin
            if (r_trigCh == 3'(k)) begin
                w_trigSample = i_probe_in[(k % NCH) * W +: W];
            end
        end
    end
`else
    logic               w_unused;
    assign w_unused = ^{i_trig_en, i_trig_ch, i_trig_val, i_post_len};
`endif

    assign w_stepStrobe = r_stepS2 & ~r_stepD;
    assign w_armRise    = i_arm & ~r_armD;
    assign w_rdAddr     = r_wptr - AW'(1) - i_rd_idx;

    // State register
    always_ff @(posedge i_lab_clk or negedge i_lab_reset) begin
        if (!i_lab_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state plus capture/session control; stop outranks both the
    // trigger path and a simultaneous arm edge
    always_comb begin
        w_stateNext    = r_state;
        w_capture      = 1'b0;
        w_startSession = 1'b0;
        w_trigHit      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_armRise && !i_stop) begin
                    w_startSession = 1'b1;
                    w_stateNext    = S_RUN;
                end
            end
            S_RUN: begin
                w_capture = w_stepStrobe;
`ifdef LAB_PROBE_TRIG_EN
                if (w_stepStrobe && r_trigEn && (w_trigSample == r_trigVal)) begin
                    w_trigHit   = 1'b1;
                    w_stateNext = (r_postLen == '0) ? S_DONE : S_POST;
                end
`endif
                if (i_stop) begin
                    w_stateNext = S_DONE;
                end
            end
            S_POST: begin
                w_capture = w_stepStrobe;
`ifdef LAB_PROBE_TRIG_EN
                if (w_stepStrobe && (r_postCnt == AW'(1))) begin
                    w_stateNext = S_DONE;
                end
`endif
                if (i_stop) begin
                    w_stateNext = S_DONE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Step synchroniser, arm edge detector, pointers, counters and read port
    always_ff @(posedge i_lab_clk or negedge i_lab_reset) begin
        if (!i_lab_reset) begin
            r_stepS1    <= 1'b0;
            r_stepS2    <= 1'b0;
            r_stepD     <= 1'b0;
            r_armD      <= 1'b0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_triggered <= 1'b0;
            r_stepCnt   <= '0;
            r_rdData    <= '0;
        end else begin
            r_stepS1 <= i_step_clk;
            r_stepS2 <= r_stepS1;
            r_stepD  <= r_stepS2;
            r_armD   <= i_arm;
            if (w_stepStrobe) begin
                r_stepCnt <= r_stepCnt + 32'd1;
            end
            if (w_startSession) begin
                r_wptr      <= '0;
                r_count     <= '0;
                r_triggered <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_wptr <= r_wptr + AW'(1);
                    if (r_count != (AW+1)'(DEPTH)) begin
                        r_count <= r_count + (AW+1)'(1);
                    end
                end
                if (w_trigHit) begin
                    r_triggered <= 1'b1;
                end
            end
            // Entries at or beyond count are stale (previous session or
            // never written), so they read as zero
            if ({1'b0, i_rd_idx} < r_count) begin
                r_rdData <= r_mem[w_rdAddr];
            end else begin
                r_rdData <= '0;
            end
        end
    end

`ifdef LAB_PROBE_TRIG_EN
    // Trigger configuration is frozen for the whole session at the arm edge
    always_ff @(posedge i_lab_clk or negedge i_lab_reset) begin
        if (!i_lab_reset) begin
            r_trigEn  <= 1'b0;
            r_trigCh  <= '0;
            r_trigVal <= '0;
            r_postLen <= '0;
            r_postCnt <= '0;
        end else begin
            if (w_startSession) begin
                r_trigEn  <= i_trig_en;
                r_trigCh  <= i_trig_ch;
                r_trigVal <= i_trig_val;
                r_postLen <= i_post_len;
            end
            if (w_trigHit) begin
                r_postCnt <= r_postLen;
            end else if (w_capture && (r_state == S_POST)) begin
                r_postCnt <= r_postCnt - AW'(1);
            end
        end
    end
`endif

    // History storage has no reset: after reset count is 0, so nothing
    // stored is reachable
    always_ff @(posedge i_lab_clk) begin
        if (w_capture) begin
            r_mem[r_wptr] <= i_probe_in;
        end
    end

    assign o_rd_data   = r_rdData;
    assign o_count     = r_count;
    assign o_state     = r_state;
    assign o_triggered = r_triggered;
    assign o_step_cnt  = r_stepCnt;

endmodule

// File: tb/tb_lab_probe_trace.sv
// ---------------------------------------------------------------------------
// tb_lab_probe_trace
//
// Directed bench for lab_probe_trace with NCH=8, W=16, DEPTH=16. Channel k
// of step n carries n with k in the top nibble, except channel 2 which
// carries n alone so it can be used as the trigger channel.
// ---------------------------------------------------------------------------
module tb_lab_probe_trace;

    localparam int NCH   = 8;
    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic              lab_clk;
    logic              lab_reset;
    logic              step_clk;
    logic [NCH*W-1:0]  probe_in;
    logic              arm;
    logic              stop;
    logic              trig_en;
    logic [2:0]        trig_ch;
    logic [W-1:0]      trig_val;
    logic [AW-1:0]     post_len;
    logic [AW-1:0]     rd_idx;
    logic [NCH*W-1:0]  rd_data;
    logic [AW:0]       count;
    logic [1:0]        state;
    logic              triggered;
    logic [31:0]       step_cnt;

    int nChecks = 0;
    int nPass   = 0;
    int expStepCnt = 0;

    lab_probe_trace #(
        .NCH   (NCH),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .i_lab_clk   (lab_clk),
        .i_lab_reset (lab_reset),
        .i_step_clk  (step_clk),
        .i_probe_in  (probe_in),
        .i_arm       (arm),
        .i_stop      (stop),
        .i_trig_en   (trig_en),
        .i_trig_ch   (trig_ch),
        .i_trig_val  (trig_val),
        .i_post_len  (post_len),
        .i_rd_idx    (rd_idx),
        .o_rd_data   (rd_data),
        .o_count     (count),
        .o_state     (state),
        .o_triggered (triggered),
        .o_step_cnt  (step_cnt)
    );

    initial begin
        lab_clk = 1'b0;
        forever #25 lab_clk = ~lab_clk;
    end

    function automatic logic [NCH*W-1:0] expVec(input logic [15:0] n);
        logic [NCH*W-1:0] v;
        for (int k = 0; k < NCH; k++) begin
            v[k*W +: W] = (k == 2) ? n : (n | 16'(k << 12));
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge lab_clk);
        #1;
    endtask

    task automatic applyStep(input logic [15:0] n, input int hold);
        probe_in = expVec(n);
        step_clk = 1'b1;
        repeat (hold) tick();
        step_clk = 1'b0;
        repeat (4) tick();
        expStepCnt++;
    endtask

    task automatic applyArm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        // power-on reset
        #10 lab_reset = 1'b0;
        repeat (3) tick();
        lab_reset = 1'b1;
        tick();
        nChecks++; if (state !== 2'd0) $display("[TB] FAIL por_state got=%0d exp=0", state); else nPass++;
        nChecks++; if (count !== 5'd0) $display("[TB] FAIL por_count got=%0d exp=0", count); else nPass++;
        // reset in the middle of a running session
        trig_en = 1'b0;
        applyArm();
        applyStep(16'd100, 4);
        applyStep(16'd101, 4);
        nChecks++; if (count !== 5'd2) $display("[TB] FAIL pre_reset_count got=%0d exp=2", count); else nPass++;
        #5 lab_reset = 1'b0;
        #1;
        nChecks++; if (rd_data !== '0) $display("[TB] FAIL rst_rd_data got=%h exp=0", rd_data); else nPass++;
        nChecks++; if (count !== 5'd0) $display("[TB] FAIL rst_count got=%0d exp=0", count); else nPass++;
        nChecks++; if (state !== 2'd0) $display("[TB] FAIL rst_state got=%0d exp=0", state); else nPass++;
        nChecks++; if (step_cnt !== 32'd0) $display("[TB] FAIL rst_step_cnt got=%0d exp=0", step_cnt); else nPass++;
        nChecks++; if (triggered !== 1'b0) $display("[TB] FAIL rst_triggered got=%0d exp=0", triggered); else nPass++;
        expStepCnt = 0;
        tick();
        lab_reset = 1'b1;
        tick();
    endtask

    task automatic test_free_run();
        trig_en = 1'b0;
        applyArm();
        nChecks++; if (state !== 2'd1) $display("[TB] FAIL fr_armed_state got=%0d exp=1", state); else nPass++;
        for (int n = 1; n <= 20; n++) applyStep(16'(n), 4);
        nChecks++; if (count !== 5'd16) $display("[TB] FAIL fr_count got=%0d exp=16", count); else nPass++;
        rd_idx = 4'd0;
        tick();
        nChecks++; if (rd_data !== expVec(16'd20)) $display("[TB] FAIL fr_rd0 got=%h exp=%h", rd_data, expVec(16'd20)); else nPass++;
        rd_idx = 4'd15;
        tick();
        nChecks++; if (rd_data !== expVec(16'd5)) $display("[TB] FAIL fr_rd15 got=%h exp=%h", rd_data, expVec(16'd5)); else nPass++;
        rd_idx = 4'd6;
        tick();
        nChecks++; if (rd_data !== expVec(16'd14)) $display("[TB] FAIL fr_rd6 got=%h exp=%h", rd_data, expVec(16'd14)); else nPass++;
        nChecks++; if (step_cnt !== 32'(expStepCnt)) $display("[TB] FAIL fr_step_cnt got=%0d exp=%0d", step_cnt, expStepCnt); else nPass++;
        nChecks++; if (state !== 2'd1) $display("[TB] FAIL fr_state got=%0d exp=1", state); else nPass++;
    endtask

    task automatic test_stop_arm();
        stop = 1'b1;
        arm  = 1'b1;
        tick();
        nChecks++; if (state !== 2'd3) $display("[TB] FAIL sa_state got=%0d exp=3", state); else nPass++;
        tick();
        nChecks++; if (count !== 5'd16) $display("[TB] FAIL sa_count_held got=%0d exp=16", count); else nPass++;
        stop = 1'b0;
        arm  = 1'b0;
        tick();
        nChecks++; if (state !== 2'd3) $display("[TB] FAIL sa_done_hold got=%0d exp=3", state); else nPass++;
        applyArm();
        nChecks++; if (state !== 2'd1) $display("[TB] FAIL sa_rearm_state got=%0d exp=1", state); else nPass++;
        nChecks++; if (count !== 5'd0) $display("[TB] FAIL sa_rearm_count got=%0d exp=0", count); else nPass++;
    endtask

    task automatic test_out_of_range();
        for (int n = 21; n <= 24; n++) applyStep(16'(n), 4);
        nChecks++; if (count !== 5'd4) $display("[TB] FAIL oor_count got=%0d exp=4", count); else nPass++;
        rd_idx = 4'd3;
        tick();
        nChecks++; if (rd_data !== expVec(16'd21)) $display("[TB] FAIL oor_rd3 got=%h exp=%h", rd_data, expVec(16'd21)); else nPass++;
        rd_idx = 4'd4;
        tick();
        nChecks++; if (rd_data !== '0) $display("[TB] FAIL oor_rd4 got=%h exp=0", rd_data); else nPass++;
    endtask

    task automatic test_step_hold();
        applyStep(16'd25, 50);
        nChecks++; if (count !== 5'd5) $display("[TB] FAIL hold_count got=%0d exp=5", count); else nPass++;
        nChecks++; if (step_cnt !== 32'(expStepCnt)) $display("[TB] FAIL hold_step_cnt got=%0d exp=%0d", step_cnt, expStepCnt); else nPass++;
        rd_idx = 4'd0;
        tick();
        nChecks++; if (rd_data !== expVec(16'd25)) $display("[TB] FAIL hold_rd0 got=%h exp=%h", rd_data, expVec(16'd25)); else nPass++;
    endtask

    task automatic test_trigger();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        trig_en  = 1'b1;
        trig_ch  = 3'd2;
        trig_val = 16'h0007;
        post_len = 4'd3;
        applyArm();
`ifdef LAB_PROBE_TRIG_EN
        for (int n = 1; n <= 6; n++) applyStep(16'(n), 4);
        nChecks++; if (triggered !== 1'b0) $display("[TB] FAIL trg_early got=%0d exp=0", triggered); else nPass++;
        applyStep(16'd7, 4);
        nChecks++; if (triggered !== 1'b1) $display("[TB] FAIL trg_hit got=%0d exp=1", triggered); else nPass++;
        nChecks++; if (state !== 2'd2) $display("[TB] FAIL trg_post_state got=%0d exp=2", state); else nPass++;
        applyStep(16'd8, 4);
        applyStep(16'd9, 4);
        nChecks++; if (state !== 2'd2) $display("[TB] FAIL trg_still_post got=%0d exp=2", state); else nPass++;
        applyStep(16'd10, 4);
        nChecks++; if (state !== 2'd3) $display("[TB] FAIL trg_done got=%0d exp=3", state); else nPass++;
        nChecks++; if (count !== 5'd10) $display("[TB] FAIL trg_count got=%0d exp=10", count); else nPass++;
        rd_idx = 4'd3;
        tick();
        nChecks++; if (rd_data !== expVec(16'd7)) $display("[TB] FAIL trg_rd3 got=%h exp=%h", rd_data, expVec(16'd7)); else nPass++;
        applyStep(16'd11, 4);
        applyStep(16'd12, 4);
        rd_idx = 4'd0;
        tick();
        nChecks++; if (count !== 5'd10) $display("[TB] FAIL trg_count_held got=%0d exp=10", count); else nPass++;
        nChecks++; if (rd_data !== expVec(16'd10)) $display("[TB] FAIL trg_hist_held got=%h exp=%h", rd_data, expVec(16'd10)); else nPass++;
`else
        for (int n = 1; n <= 10; n++) applyStep(16'(n), 4);
        nChecks++; if (triggered !== 1'b0) $display("[TB] FAIL notrg_triggered got=%0d exp=0", triggered); else nPass++;
        nChecks++; if (state !== 2'd1) $display("[TB] FAIL notrg_state got=%0d exp=1", state); else nPass++;
        nChecks++; if (count !== 5'd10) $display("[TB] FAIL notrg_count got=%0d exp=10", count); else nPass++;
        rd_idx = 4'd3;
        tick();
        nChecks++; if (rd_data !== expVec(16'd7)) $display("[TB] FAIL notrg_rd3 got=%h exp=%h", rd_data, expVec(16'd7)); else nPass++;
`endif
        nChecks++; if (step_cnt !== 32'(expStepCnt)) $display("[TB] FAIL trg_step_cnt got=%0d exp=%0d", step_cnt, expStepCnt); else nPass++;
    endtask

    initial begin
        lab_reset = 1'b1;
        step_clk  = 1'b0;
        probe_in  = '0;
        arm       = 1'b0;
        stop      = 1'b0;
        trig_en   = 1'b0;
        trig_ch   = 3'd0;
        trig_val  = '0;
        post_len  = '0;
        rd_idx    = '0;
        test_reset();
        test_free_run();
        test_stop_arm();
        test_out_of_range();
        test_step_hold();
        test_trigger();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
